// File: rtl/bit_serializer.sv
// bit_serializer: sends a parallel word one bit at a time as mutually exclusive
// one/zero four-phase requests, with ack synchronisation, done and timeout abort.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 1024,
    localparam int BW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             one,
    output logic             zero,
    input  logic             ack,
    output logic             done,
    output logic             err,
    output logic [BW-1:0]    bits_left
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW:0] T_ONE = (TW+1)'(1);
    localparam logic [TW:0] T_LIM = (TW+1)'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ARM, REQ, DROP, DONE} state_t;

    state_t           state, state_n;
    logic             ack_m, ack_s;
    logic [WIDTH-1:0] sh, sh_n, sh_adv;
    logic [BW-1:0]    bits_n;
    logic [TW-1:0]    timer, timer_n;
    logic             one_n, zero_n, err_n;
    logic             cur_bit, nxt_bit, tmo;

    // The send end of the shift register is fixed; advancing moves the next bit there.
    assign cur_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign sh_adv  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    assign nxt_bit = MSB_FIRST ? sh_adv[WIDTH-1] : sh_adv[0];
    assign tmo     = (TIMEOUT != 0) && (({1'b0, timer} + T_ONE) == T_LIM);

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            state     <= IDLE;
            sh        <= '0;
            bits_left <= '0;
            timer     <= '0;
            one       <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack_m     <= ack;
            ack_s     <= ack_m;
            state     <= state_n;
            sh        <= sh_n;
            bits_left <= bits_n;
            timer     <= timer_n;
            one       <= one_n;
            zero      <= zero_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        bits_n  = bits_left;
        timer_n = timer;
        one_n   = 1'b0;
        zero_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    sh_n    = data_in;
                    bits_n  = BW'(WIDTH);
                    state_n = ARM;
                end
            end
            // Wait for a quiet ack so a stale one cannot complete the first bit.
            ARM: begin
                if (!ack_s) begin
                    state_n = REQ;
                    one_n   = cur_bit;
                    zero_n  = ~cur_bit;
                    timer_n = '0;
                end
            end
            REQ: begin
                one_n  = one;
                zero_n = zero;
                if (ack_s) begin
                    state_n = DROP;
                    one_n   = 1'b0;
                    zero_n  = 1'b0;
                    timer_n = '0;
                end else if (tmo) begin
                    state_n = IDLE;
                    one_n   = 1'b0;
                    zero_n  = 1'b0;
                    bits_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    if (bits_left == BW'(1)) begin
                        bits_n  = '0;
                        state_n = DONE;
                    end else begin
                        bits_n  = bits_left - BW'(1);
                        sh_n    = sh_adv;
                        state_n = REQ;
                        one_n   = nxt_bit;
                        zero_n  = ~nxt_bit;
                        timer_n = '0;
                    end
                end else if (tmo) begin
                    state_n = IDLE;
                    bits_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule
